// File: rtl/rtc_lector_if.sv
// Pin bundle of the multiplexed address/data RTC chip.
// The lector is the bus master; the chip (or its model) is the slave.
interface rtc_lector_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/rtc_lector.sv
// Sweeps the nine RTC time/date/timer registers after a transfer command
// and presents each one as a Dir/Dato pair with a one-cycle valid pulse.
module rtc_lector #(
    parameter int T_PULSE = 10,
    parameter int T_GAP   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    rtc_lector_if.master        bus,
    output logic [7:0]          Dir,
    output logic [7:0]          Dato,
    output logic                dato_valid,
    output logic                busy,
    output logic                done
);

    localparam int CNT_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(T_GAP - 1);
    localparam logic [3:0]       LAST_IDX  = 4'd8;
    localparam logic [7:0]       CMD_XFER  = 8'hF0;

    typedef enum logic [2:0] {
        IDLE, CMD_PH, CMD_GAP, ADR_PH, ADR_GAP, DAT_PH, DAT_GAP, FIN
    } state_t;

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_addr = 8'h21;
            4'd1:    reg_addr = 8'h22;
            4'd2:    reg_addr = 8'h23;
            4'd3:    reg_addr = 8'h24;
            4'd4:    reg_addr = 8'h25;
            4'd5:    reg_addr = 8'h26;
            4'd6:    reg_addr = 8'h41;
            4'd7:    reg_addr = 8'h42;
            4'd8:    reg_addr = 8'h43;
            default: reg_addr = 8'h00;
        endcase
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       idx, idx_n;
    logic             start_q;
    logic             cap;

    logic       cs_n_r, rd_n_r, wr_n_r, a_d_r, ad_oe_r;
    logic       cs_n_n, rd_n_n, wr_n_n, a_d_n, ad_oe_n;
    logic [7:0] ad_out_r, ad_out_n;
    logic       busy_r, busy_n, done_r, done_n;
    logic [7:0] dir_p1, dato_p1;
    logic       vld_p1;

    assign cap = (state == DAT_PH) && (cnt == PULSE_END);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = idx;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (start_q) state_n = CMD_PH;
            end
            CMD_PH: if (cnt == PULSE_END) begin cnt_n = '0; state_n = CMD_GAP; end
            ADR_PH: if (cnt == PULSE_END) begin cnt_n = '0; state_n = ADR_GAP; end
            DAT_PH: if (cnt == PULSE_END) begin cnt_n = '0; state_n = DAT_GAP; end
            CMD_GAP: if (cnt == GAP_END) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = ADR_PH;
            end
            ADR_GAP: if (cnt == GAP_END) begin cnt_n = '0; state_n = DAT_PH; end
            DAT_GAP: if (cnt == GAP_END) begin
                cnt_n = '0;
                if (idx == LAST_IDX) begin
                    state_n = FIN;
                end else begin
                    idx_n   = idx + 4'd1;
                    state_n = ADR_PH;
                end
            end
            FIN: begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Pin levels are decoded from the next state so the registered
        // strobes line up exactly with the state they belong to.
        cs_n_n   = 1'b1;
        rd_n_n   = 1'b1;
        wr_n_n   = 1'b1;
        a_d_n    = 1'b1;
        ad_oe_n  = 1'b0;
        ad_out_n = 8'h00;
        case (state_n)
            CMD_PH: begin
                cs_n_n = 1'b0; wr_n_n = 1'b0; a_d_n = 1'b0; ad_oe_n = 1'b1;
                ad_out_n = CMD_XFER;
            end
            ADR_PH: begin
                cs_n_n = 1'b0; wr_n_n = 1'b0; a_d_n = 1'b0; ad_oe_n = 1'b1;
                ad_out_n = reg_addr(idx_n);
            end
            DAT_PH: begin
                cs_n_n = 1'b0; rd_n_n = 1'b0;
            end
            default: ;
        endcase
        busy_n = (state_n != IDLE) && (state_n != FIN);
        done_n = (state_n == FIN);
    end

    // Control stage: FSM, counters and registered pin drivers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            start_q  <= 1'b0;
            cs_n_r   <= 1'b1;
            rd_n_r   <= 1'b1;
            wr_n_r   <= 1'b1;
            a_d_r    <= 1'b1;
            ad_oe_r  <= 1'b0;
            ad_out_r <= 8'h00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            start_q  <= start && (state == IDLE) && !start_q;
            cs_n_r   <= cs_n_n;
            rd_n_r   <= rd_n_n;
            wr_n_r   <= wr_n_n;
            a_d_r    <= a_d_n;
            ad_oe_r  <= ad_oe_n;
            ad_out_r <= ad_out_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            vld_p1   <= cap;
        end
    end

    // Capture stage: sample the pad on the last read-strobe cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_p1  <= 8'h00;
            dato_p1 <= 8'h00;
        end else if (cap) begin
            dir_p1  <= reg_addr(idx);
            dato_p1 <= bus.ad_in;
        end
    end

    assign bus.cs_n   = cs_n_r;
    assign bus.rd_n   = rd_n_r;
    assign bus.wr_n   = wr_n_r;
    assign bus.a_d    = a_d_r;
    assign bus.ad_oe  = ad_oe_r;
    assign bus.ad_out = ad_out_r;
    assign Dir        = dir_p1;
    assign Dato       = dato_p1;
    assign dato_valid = vld_p1;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_rtc_lector.sv
// Bench for rtc_lector: RTC chip model with a register array, a bus-protocol
// monitor on the default-timing instance, and a short-timing second instance.
module tb_rtc_lector;

    localparam int TP_A  = 10;
    localparam int TG_A  = 5;
    localparam int TP_B  = 2;
    localparam int TG_B  = 1;
    localparam int LEN_A = (TP_A + TG_A) + 9 * 2 * (TP_A + TG_A) + 1;
    localparam int LEN_B = (TP_B + TG_B) + 9 * 2 * (TP_B + TG_B) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    rtc_lector_if bus_a ();
    rtc_lector_if bus_b ();

    logic [7:0] dir_a, dato_a, dir_b, dato_b;
    logic       vld_a, busy_a, done_a, vld_b, busy_b, done_b;

    rtc_lector #(.T_PULSE(TP_A), .T_GAP(TG_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a.master),
        .Dir(dir_a), .Dato(dato_a), .dato_valid(vld_a), .busy(busy_a), .done(done_a)
    );

    rtc_lector #(.T_PULSE(TP_B), .T_GAP(TG_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b.master),
        .Dir(dir_b), .Dato(dato_b), .dato_valid(vld_b), .busy(busy_b), .done(done_b)
    );

    logic [7:0] reg_list [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] mem [256];
    logic [7:0] adr_a = 8'h00;
    logic [7:0] adr_b = 8'h00;

    // RTC chip model: latches the address on a write phase, returns mem[] while RD is low
    always @(posedge clk) begin
        if (!bus_a.cs_n && !bus_a.wr_n && !bus_a.a_d) adr_a <= bus_a.ad_out;
        if (!bus_b.cs_n && !bus_b.wr_n && !bus_b.a_d) adr_b <= bus_b.ad_out;
    end
    assign bus_a.ad_in = !bus_a.rd_n ? mem[adr_a] : 8'h00;
    assign bus_b.ad_in = !bus_b.rd_n ? mem[adr_b] : 8'h00;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_wr(input int ord);
        logic [7:0] v;
        v = 8'hF0;
        if (ord >= 1 && ord <= 9) v = reg_list[ord - 1];
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 9; i++) mem[reg_list[i]] = 8'($urandom);
    endtask

    // Protocol monitor on instance A: strobe widths, gaps, overlap and write-phase values
    initial begin
        int  lo_len, gap_len, wr_ord;
        bit  seen_lo, lo_wr;
        lo_len = 0; gap_len = 0; wr_ord = 0; seen_lo = 0; lo_wr = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                lo_len = 0; gap_len = 0; wr_ord = 0; seen_lo = 0;
            end else begin
                chk("rd_wr_overlap", 64'(!bus_a.rd_n && !bus_a.wr_n), 0);
                chk("rd_with_oe", 64'(!bus_a.rd_n && bus_a.ad_oe), 0);
                if (!bus_a.wr_n || !bus_a.rd_n) begin
                    if (lo_len == 0) begin
                        if (seen_lo) chk("gap_width_min", 64'(gap_len >= TG_A), 1);
                        lo_wr = !bus_a.wr_n;
                    end
                    lo_len++;
                    gap_len = 0;
                    if (!bus_a.wr_n)
                        chk("wr_phase_pins", {bus_a.ad_out, bus_a.a_d, bus_a.ad_oe, bus_a.cs_n},
                            {exp_wr(wr_ord), 1'b0, 1'b1, 1'b0});
                    else
                        chk("rd_phase_pins", {bus_a.a_d, bus_a.ad_oe, bus_a.cs_n}, 3'b100);
                end else begin
                    if (lo_len != 0) begin
                        chk(lo_wr ? "wr_low_width" : "rd_low_width", lo_len, TP_A);
                        seen_lo = 1;
                        if (lo_wr) wr_ord++;
                    end
                    lo_len = 0;
                    gap_len++;
                    if (!busy_a) begin wr_ord = 0; seen_lo = 0; end
                end
            end
        end
    end

    task automatic run_sweep(input bit sel, input bit spam);
        logic [15:0] q[$];
        logic [15:0] e;
        int  n, exp_len;
        bit  fin;
        logic       vld, bsy, dn;
        logic [7:0] dir, dato;
        exp_len = sel ? LEN_B : LEN_A;
        for (int i = 0; i < 9; i++) q.push_back({reg_list[i], mem[reg_list[i]]});
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        n = 0;
        fin = 0;
        while (!fin && n <= exp_len + 20) begin
            @(negedge clk);
            if (sel) start_b = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            else     start_a = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            vld  = sel ? vld_b  : vld_a;
            bsy  = sel ? busy_b : busy_a;
            dn   = sel ? done_b : done_a;
            dir  = sel ? dir_b  : dir_a;
            dato = sel ? dato_b : dato_a;
            if (vld) begin
                if (q.size() == 0) begin
                    chk("extra_dato_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("dir_dato", {dir, dato}, e);
                end
            end
            if (dn) begin
                fin = 1;
                chk("done_cycle", n, exp_len);
                chk("busy_at_done", bsy, 0);
                chk("all_regs_read", q.size(), 0);
                if (spam) begin
                    if (sel) start_b = 1'b1; else start_a = 1'b1;
                end
            end else begin
                chk("busy_during_sweep", bsy, 64'(n >= 1));
            end
            n++;
        end
        if (!fin) chk("sweep_timeout", 0, 1);
    endtask

    initial begin
        int  nv, rdc;
        bit  hit;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        chk("rst_pins_a", {bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.a_d, bus_a.ad_oe, bus_a.ad_out}, {5'b11110, 8'h00});
        chk("rst_outs_a", {dir_a, dato_a, vld_a, busy_a, done_a}, 0);
        chk("rst_pins_b", {bus_b.cs_n, bus_b.rd_n, bus_b.wr_n, bus_b.a_d, bus_b.ad_oe, bus_b.ad_out}, {5'b11110, 8'h00});
        chk("rst_outs_b", {dir_b, dato_b, vld_b, busy_b, done_b}, 0);
        #2 rst = 1'b1;

        repeat (100) begin
            @(negedge clk);
            chk("idle_a", {bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.a_d, bus_a.ad_oe, bus_a.ad_out,
                           dir_a, dato_a, vld_a, busy_a, done_a}, {5'b11110, 27'd0});
        end

        // Fixed data Dir+0x10, then random data with start spammed while busy and at done
        run_sweep(1'b0, 1'b0);
        @(negedge clk);
        fill_random();
        run_sweep(1'b0, 1'b1);
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) begin
            chk("idle_after_done", {busy_a, vld_a, done_a, bus_a.cs_n}, 4'b0001);
            @(negedge clk);
        end

        // Reset in the middle of the data phase for index 4
        fill_random();
        start_a = 1'b1;
        nv = 0; rdc = 0; hit = 0;
        for (int c = 0; c < LEN_A && !hit; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (vld_a) nv++;
            if (nv == 4 && !bus_a.rd_n) begin
                rdc++;
                if (rdc == 4) hit = 1;
            end
        end
        chk("reached_dat_ph_idx4", hit, 1);
        chk("dir_before_reset", dir_a, 8'h24);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pins", {bus_a.cs_n, bus_a.rd_n, bus_a.wr_n, bus_a.a_d, bus_a.ad_oe}, 5'b11110);
        chk("async_rst_data", {dir_a, dato_a, busy_a}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("no_vld_in_reset", {vld_a, dir_a, dato_a}, 0);
        end
        #2 rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("idle_after_reset", {busy_a, vld_a, done_a, bus_a.cs_n, bus_a.rd_n, dir_a, dato_a}, {5'b00011, 16'h0});
        end

        // Short timing instance
        fill_random();
        run_sweep(1'b1, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
